fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder stage placed directly after the 16-point radix-2^2 SDF FFT top.
//  - The FFT emits bins in bit-reversed order, one complex sample per Data_Valid.
//  - This block captures each 16-sample frame into a ping-pong buffer at bit-reversed addresses.
//  - It replays the frame in natural bin order (0..N-1) with valid, last and bin-index tags.
//  - Any CORDIC/magnitude or host-interface consumer therefore sees bins in natural order.
// PARAMETERS
//  WIDTH  16  sample width, signed two's complement, per real/imag component
//  N      16  FFT length = samples per frame (power of two)
//  LOG2N  4   log2(N); address/index width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  In_Re      in   WIDTH  FFT output real part (bit-reversed order)
//  In_Im      in   WIDTH  FFT output imaginary part
//  In_Valid   in   1      sample qualifier (driven by FFT Data_Valid); may be gapped
//  Out_Re     out  WIDTH  reordered real part, registered
//  Out_Im     out  WIDTH  reordered imaginary part, registered
//  Out_Valid  out  1      Out_* hold a valid bin this cycle
//  Out_Index  out  LOG2N  natural bin index of the current Out_* sample
//  Out_Last   out  1      high with bin N-1 (end of frame)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; wr_cnt=0, wr_bank=0, full[1:0]=0, reader IDLE, rd_cnt=0.
//  - Memory contents are not reset.
//  Write side:
//  - On each edge with In_Valid=1: mem[wr_bank][bitrev(wr_cnt)] <= {In_Re,In_Im}; wr_cnt++.
//  - When wr_cnt=N-1 is written: wr_cnt wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
//  - No backpressure exists: the writer never stalls.
//  - Full-rate input cannot overrun a bank still being read (the reader drains N in N cycles).
//  - If the writer enters a bank whose full flag is still set: drop nothing, overwrite the bank.
//    This is a verification error; the bench shall flag it.
//  Read side, FSM IDLE/READ:
//  - IDLE: if full[rd_bank] -> READ and drive bin 0 on the same edge.
//  - READ: each edge outputs mem[rd_bank][rd_cnt]; Out_Index=rd_cnt; Out_Valid=1; Out_Last=(rd_cnt==N-1).
//  - At rd_cnt=N-1: clear full[rd_bank], toggle rd_bank, rd_cnt=0.
//    If full[new bank] is already set, stay in READ (gap-free); else go to IDLE.
//  - IDLE outputs: Out_Valid=0, Out_Last=0, Out_Index=0; Out_Re/Out_Im hold their last value.
//  Latency: the edge E capturing the last input sample sets full.
//  - Bin 0 is presented after edge E+1; bin N-1 after edge E+N.
//  Simultaneous set/clear:
//  - A writer set and a reader clear of the same full bit in one cycle cannot occur legally.
//  - Set and clear on different banks in one cycle are independent.
//  Memory read is combinational from the register array; the output is registered.
//  Arithmetic: pure data movement; no scaling, rounding or sign change.
//  Reset mid-frame or mid-readout: the partial frame is discarded.
//  - The next In_Valid after release is treated as sample 0 of a new frame.
// STRUCTURE
//  Shared package fft_pkg: WIDTH, N, LOG2N constants and function bitrev(LOG2N-bit).
//  Sub-module fft_reorder_bank: 2xN x 2*WIDTH register array.
//  - Ports: write port (bank, addr, data, we); async read port (bank, addr).
//  Top module holds the write counter, bank flags and the read FSM.
// TESTING
//  1 Single frame, In_Re=i, In_Im=-i, i=0..15 contiguous
//    -> Out_Re = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; Out_Im = negation.
//    -> Out_Valid for 16 cycles starting at E+1; Out_Last only on the 16th.
//  2 32 contiguous valids (two frames)
//    -> 32 gap-free Out_Valid cycles; Out_Index 0..15, 0..15; frame-2 data correct; no overwrite flag.
//  3 Gapped input: In_Valid toggling 1,0,1,0 for one frame
//    -> identical ordering to test 1; readout starts at E+1 after the 16th valid.
//  4 Reset pulse after 7 input samples, then a fresh 16-sample frame
//    -> no output from the partial frame; the new frame reorders correctly.
//  5 Reset during readout at bin 5
//    -> Out_Valid=0 and outputs 0 immediately (async); no residual bins after release.
//  6 Extremes: In_Re=-32768, In_Im=32767 at bit-reversed slot 1 (input sample 8)
//    -> emitted unchanged as bin 1.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, read-FSM state type and bit-reversal helper for the FFT output reorder stage.
package fft_pkg;

    localparam int WIDTH = 16;
    localparam int N     = 16;
    localparam int LOG2N = 4;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream into the reorder stage (bit-reversed) and out of it (natural order, tagged).
interface fft_bitrev_reorder_if;
    import fft_pkg::*;

    logic [WIDTH-1:0] In_Re;
    logic [WIDTH-1:0] In_Im;
    logic             In_Valid;
    logic [WIDTH-1:0] Out_Re;
    logic [WIDTH-1:0] Out_Im;
    logic             Out_Valid;
    logic [LOG2N-1:0] Out_Index;
    logic             Out_Last;

    modport master (
        output In_Re, In_Im, In_Valid,
        input  Out_Re, Out_Im, Out_Valid, Out_Index, Out_Last
    );

    modport slave (
        input  In_Re, In_Im, In_Valid,
        output Out_Re, Out_Im, Out_Valid, Out_Index, Out_Last
    );

endinterface

// File: rtl/fft_bitrev_reorder_bank.sv
// Ping-pong sample store: two banks of N complex samples, one write port, one combinational read port.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic               wr_bank,
    input  logic [LOG2N-1:0]   wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic               rd_bank,
    input  logic [LOG2N-1:0]   rd_addr,
    output logic [2*WIDTH-1:0] rd_data
);

    logic [2*WIDTH-1:0] mem_q [2][N];
    logic [2*WIDTH-1:0] mem_d [2][N];

    // Contents are intentionally not reset; the bank flags decide what is meaningful.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_bank][wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Captures bit-reversed FFT frames into a ping-pong store and replays them in natural bin order.
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fft_bitrev_reorder_if.slave bus
);

    rd_state_e          state_q, state_d;
    logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic [1:0]         full_q, full_d;
    logic               rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WIDTH-1:0]   out_re_q, out_re_d;
    logic [WIDTH-1:0]   out_im_q, out_im_d;
    logic               out_valid_q, out_valid_d;
    logic [LOG2N-1:0]   out_index_q, out_index_d;
    logic               out_last_q, out_last_d;

    logic [1:0]         set_mask;
    logic [1:0]         clr_mask;
    logic               emit;
    logic [LOG2N-1:0]   wr_addr;
    logic [2*WIDTH-1:0] rd_data;

    assign wr_addr = bitrev(wr_cnt_q);

    fft_reorder_bank u_bank (
        .clk     (clk),
        .we      (bus.In_Valid),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data ({bus.In_Re, bus.In_Im}),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data)
    );

    // rd_cnt is always 0 while idle, so the IDLE->READ edge already presents bin 0.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_valid_d = 1'b0;
        out_index_d = '0;
        out_last_d  = 1'b0;
        set_mask    = '0;
        clr_mask    = '0;
        emit        = 1'b0;

        if (bus.In_Valid) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_cnt_q == LAST_IDX) begin
                set_mask[wr_bank_q] = 1'b1;
                wr_bank_d           = !wr_bank_q;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = RD_READ;
                    emit    = 1'b1;
                end
            end
            RD_READ: begin
                emit = 1'b1;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        if (emit) begin
            out_re_d    = rd_data[2*WIDTH-1:WIDTH];
            out_im_d    = rd_data[WIDTH-1:0];
            out_valid_d = 1'b1;
            out_index_d = rd_cnt_q;
            out_last_d  = (rd_cnt_q == LAST_IDX);
            rd_cnt_d    = rd_cnt_q + LOG2N'(1);
            if (rd_cnt_q == LAST_IDX) begin
                clr_mask[rd_bank_q] = 1'b1;
                rd_bank_d           = !rd_bank_q;
                if (!full_q[!rd_bank_q]) begin
                    state_d = RD_IDLE;
                end
            end
        end

        full_d = (full_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RD_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.Out_Re    = out_re_q;
    assign bus.Out_Im    = out_im_q;
    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Index = out_index_q;
    assign bus.Out_Last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the FFT reorder stage: frame-level reference model with a cycle-stamped expectation queue.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_bitrev_reorder_if bus ();

    fft_bitrev_reorder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] frame_re[16];
    logic [15:0] frame_im[16];
    int          frame_cnt;
    int          cycle;
    int          last_sched;
    int          bank_end[2];
    int          model_bank;
    int          overwrite_cnt;
    logic [15:0] hold_re;
    logic [15:0] hold_im;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    function automatic int rev4(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r += 1 << (3 - b);
        end
        return r;
    endfunction

    task automatic modelReset();
        exp_q.delete();
        frame_cnt   = 0;
        model_bank  = 0;
        bank_end[0] = -1;
        bank_end[1] = -1;
        last_sched  = -1;
        hold_re     = '0;
        hold_im     = '0;
    endtask

    // A completed frame is emitted in natural order as soon as it is complete and the previous frame has drained.
    task automatic modelEdge(input bit v, input logic [15:0] re, input logic [15:0] im);
        int   start;
        exp_t e;
        if (!v) return;
        if (frame_cnt == 0 && cycle <= bank_end[model_bank]) overwrite_cnt++;
        frame_re[frame_cnt] = re;
        frame_im[frame_cnt] = im;
        frame_cnt++;
        if (frame_cnt == 16) begin
            start = (cycle + 1 > last_sched + 1) ? cycle + 1 : last_sched + 1;
            for (int k = 0; k < 16; k++) begin
                e.cyc = start + k;
                e.re  = frame_re[rev4(k)];
                e.im  = frame_im[rev4(k)];
                e.idx = k;
                exp_q.push_back(e);
            end
            last_sched           = start + 15;
            bank_end[model_bank] = last_sched;
            model_bank           = 1 - model_bank;
            frame_cnt            = 0;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycle, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
            e = exp_q.pop_front();
            checkValue("out_valid", 32'(bus.Out_Valid), 32'd1);
            checkValue("out_index", 32'(bus.Out_Index), 32'(e.idx));
            checkValue("out_last", 32'(bus.Out_Last), (e.idx == 15) ? 32'd1 : 32'd0);
            checkValue("out_re", 32'(bus.Out_Re), 32'(e.re));
            checkValue("out_im", 32'(bus.Out_Im), 32'(e.im));
            hold_re = e.re;
            hold_im = e.im;
        end else begin
            checkValue("idle_valid", 32'(bus.Out_Valid), 32'd0);
            checkValue("idle_index", 32'(bus.Out_Index), 32'd0);
            checkValue("idle_last", 32'(bus.Out_Last), 32'd0);
            checkValue("idle_re_hold", 32'(bus.Out_Re), 32'(hold_re));
            checkValue("idle_im_hold", 32'(bus.Out_Im), 32'(hold_im));
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [15:0] re, input logic [15:0] im);
        bus.In_Valid = v;
        bus.In_Re    = re;
        bus.In_Im    = im;
        @(posedge clk);
        cycle++;
        if (rst) modelEdge(v, re, im);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0, 16'h0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput();
        idle(2);
        rst = 1'b1;
    endtask

    task automatic randomFrame();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    endtask

    task automatic drainAndCheck(input string tag);
        idle(24);
        checkValue(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        n_fail        = 0;
        cycle         = 0;
        overwrite_cnt = 0;
        bus.In_Valid  = 1'b0;
        bus.In_Re     = '0;
        bus.In_Im     = '0;
        rst           = 1'b0;
        modelReset();
        #1;
        checkOutput();
        idle(2);
        rst = 1'b1;
        idle(2);

        $display("[TB] test 1: single contiguous ramp frame");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i), 16'(-i));
        drainAndCheck("t1_all_bins_seen");

        $display("[TB] test 2: two back-to-back random frames");
        randomFrame();
        randomFrame();
        drainAndCheck("t2_all_bins_seen");
        checkValue("t2_no_overwrite", 32'(overwrite_cnt), 32'd0);

        $display("[TB] test 3: gapped ramp frame");
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 16'(i / 2), 16'(-(i / 2)));
            else            applyStimulus(1'b0, 16'h0, 16'h0);
        end
        drainAndCheck("t3_all_bins_seen");

        $display("[TB] test 4: reset after a partial frame");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
        doReset();
        randomFrame();
        drainAndCheck("t4_all_bins_seen");

        $display("[TB] test 5: reset during readout");
        randomFrame();
        for (int k = 0; k < 40 && !(exp_q.size() > 0 && exp_q[0].idx == 6); k++) idle(1);
        checkValue("t5_reached_bin5", (exp_q.size() > 0 && exp_q[0].idx == 6) ? 32'd1 : 32'd0, 32'd1);
        doReset();
        drainAndCheck("t5_no_residual");

        $display("[TB] test 6: extreme values at slot 1");
        for (int i = 0; i < 16; i++) begin
            if (i == 8) applyStimulus(1'b1, 16'h8000, 16'h7FFF);
            else        applyStimulus(1'b1, 16'($urandom), 16'($urandom));
        end
        drainAndCheck("t6_all_bins_seen");

        $display("[TB] test 7: randomly gapped frames");
        for (int n = 0; n < 48; ) begin
            if ($urandom_range(0, 2) != 0) begin
                applyStimulus(1'b1, 16'($urandom), 16'($urandom));
                n++;
            end else begin
                applyStimulus(1'b0, 16'($urandom), 16'($urandom));
            end
        end
        drainAndCheck("t7_all_bins_seen");
        checkValue("t7_no_overwrite", 32'(overwrite_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
